// File: rtl/eq_band_mac_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : eq_pkg
// Purpose: Shared widths and FSM encoding for the equalizer MAC scheduler.
//          The filter bank and gain register map import the same widths.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package eq_pkg;
  localparam int N_BANDS = 10;
  localparam int FILT_W  = 16;
  localparam int GAIN_W  = 13;
  localparam int ACC_W   = 41;
  localparam int OUT_W   = 24;
  localparam int OUT_LSB = 16;

  // Signed filter times zero-extended gain.
  localparam int PROD_W  = FILT_W + GAIN_W + 1;
  localparam int IDX_W   = $clog2(N_BANDS);

  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MAC  = 1'b1;
endpackage
`default_nettype wire

// File: rtl/eq_band_mac_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : eq_band_mac_scheduler_if
// Purpose: Sample handshake, packed filter/gain buses and audio output of the
//          equalizer MAC scheduler.
// Ports  : sample_valid, filt_bus, gain_bus    (master -> slave)
//          sample_ready, audio_out, out_valid,
//          wrap_flag, sample_drop              (slave -> master)
// Rev    : 1.0  initial release
// ============================================================================
interface eq_band_mac_scheduler_if;
  import eq_pkg::*;

  logic                        sample_valid;
  logic                        sample_ready;
  logic [N_BANDS*FILT_W-1:0]   filt_bus;
  logic [N_BANDS*GAIN_W-1:0]   gain_bus;
  logic [OUT_W-1:0]            audio_out;
  logic                        out_valid;
  logic                        wrap_flag;
  logic                        sample_drop;

  modport master (
    output sample_valid, filt_bus, gain_bus,
    input  sample_ready, audio_out, out_valid, wrap_flag, sample_drop
  );

  modport slave (
    input  sample_valid, filt_bus, gain_bus,
    output sample_ready, audio_out, out_valid, wrap_flag, sample_drop
  );
endinterface
`default_nettype wire

// File: rtl/eq_band_mac_scheduler_mac.sv
`default_nettype none
// ============================================================================
// Module : eq_mac_unit
// Purpose: Shared signed x unsigned multiplier with accumulator.
// Ports  : clk, rst_n  clock, async active-low reset
//          clr_i       zero the accumulator (new sample)
//          en_i        add the current product
//          filt_i      signed filter operand
//          gain_i      unsigned gain operand
//          sum_o       accumulator plus current product (combinational)
// Rev    : 1.0  initial release
// ============================================================================
module eq_mac_unit
  import eq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [FILT_W-1:0] filt_i,
  input  logic [GAIN_W-1:0]       gain_i,
  output logic signed [ACC_W-1:0] sum_o
);
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] w_prod;

  // Gain gets a zero MSB so it is never read as negative.
  assign w_prod = PROD_W'(filt_i) * PROD_W'($signed({1'b0, gain_i}));
  assign sum_o  = acc_q + ACC_W'(w_prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule
`default_nettype wire

// File: rtl/eq_band_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module : eq_band_mac_scheduler
// Purpose: Time-multiplexes the band weighting/summing onto one MAC, one band
//          per clock, producing sum(filt*gain)[39:16] every N_BANDS+1 clocks.
// Ports  : clk       system clock
//          rst_n     async active-low reset
//          sched_if  slave side of the sample/audio interface
// Rev    : 1.0  initial release
// ============================================================================
module eq_band_mac_scheduler
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  eq_band_mac_scheduler_if.slave   sched_if
);
  logic [0:0]                           state_q, state_d;
  idx_t                                 idx_q, idx_d;
  logic [N_BANDS-1:0][FILT_W-1:0]       filt_sh_q;
  logic [N_BANDS-1:0][GAIN_W-1:0]       gain_sh_q;
  logic [OUT_W-1:0]                     audio_q, audio_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 wrap_q, wrap_d;

  logic                                 w_idle;
  logic                                 w_accept;
  logic                                 w_last;
  logic signed [ACC_W-1:0]              w_sum;

  assign w_idle   = (state_q == ST_IDLE);
  assign w_accept = sched_if.sample_valid && w_idle;
  assign w_last   = (state_q == ST_MAC) && (idx_q == IDX_W'(N_BANDS - 1));

  eq_mac_unit u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (w_accept),
    .en_i   (state_q == ST_MAC),
    .filt_i (filt_sh_q[idx_q]),
    .gain_i (gain_sh_q[idx_q]),
    .sum_o  (w_sum)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    audio_d     = audio_q;
    wrap_d      = wrap_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sched_if.sample_valid) begin
          state_d = ST_MAC;
          idx_d   = '0;
        end
      end
      ST_MAC: begin
        if (w_last) begin
          // Final sum includes the last product, so take it from w_sum.
          state_d     = ST_IDLE;
          idx_d       = '0;
          out_valid_d = 1'b1;
          audio_d     = w_sum[OUT_LSB+OUT_W-1:OUT_LSB];
          wrap_d      = w_sum[ACC_W-1] ^ w_sum[OUT_LSB+OUT_W-1];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      audio_q     <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      audio_q     <= audio_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  // Shadow copies isolate the sample in flight from later bus changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_sh_q <= '0;
      gain_sh_q <= '0;
    end else if (w_accept) begin
      filt_sh_q <= sched_if.filt_bus;
      gain_sh_q <= sched_if.gain_bus;
    end
  end

  assign sched_if.sample_ready = w_idle;
  assign sched_if.sample_drop  = sched_if.sample_valid && (state_q == ST_MAC);
  assign sched_if.audio_out    = audio_q;
  assign sched_if.out_valid    = out_valid_q;
  assign sched_if.wrap_flag    = wrap_q;
endmodule
`default_nettype wire

// File: tb/tb_eq_band_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_eq_band_mac_scheduler
// Purpose: Self-checking bench for eq_band_mac_scheduler with a scoreboard of
//          expected audio samples and output cycles.
// Rev    : 1.0  initial release
// ============================================================================
module tb_eq_band_mac_scheduler;
  import eq_pkg::*;

  localparam int FB = N_BANDS * FILT_W;
  localparam int GB = N_BANDS * GAIN_W;

  typedef struct {
    logic [OUT_W-1:0] audio;
    logic             wrap;
    int               cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ov_count = 0;
  exp_t sb[$];
  exp_t m_e;

  eq_band_mac_scheduler_if bus_if ();

  eq_band_mac_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_if (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic exp_t model(input logic [FB-1:0] f, input logic [GB-1:0] g);
    exp_t        r;
    longint      s;
    logic [63:0] v;
    s = 0;
    for (int k = 0; k < N_BANDS; k++)
      s += longint'($signed(f[k*FILT_W +: FILT_W])) * longint'({1'b0, g[k*GAIN_W +: GAIN_W]});
    v       = s;
    r.audio = v[39:16];
    r.wrap  = v[40] ^ v[39];
    r.cyc   = 0;
    return r;
  endfunction

  // Scoreboard: push on acceptance, pop and compare on out_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.sample_valid && bus_if.sample_ready) begin
        m_e     = model(bus_if.filt_bus, bus_if.gain_bus);
        m_e.cyc = cyc + N_BANDS + 1;
        sb.push_back(m_e);
      end
      if (bus_if.out_valid) begin
        ov_count++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required no output", cyc);
        end else begin
          m_e = sb.pop_front();
          if (bus_if.audio_out !== m_e.audio) begin
            failures++;
            $display("FAIL audio_out: got %h, required %h", bus_if.audio_out, m_e.audio);
          end
          checks++;
          if (bus_if.wrap_flag !== m_e.wrap) begin
            failures++;
            $display("FAIL wrap_flag: got %b, required %b", bus_if.wrap_flag, m_e.wrap);
          end
          checks++;
          if (cyc !== m_e.cyc) begin
            failures++;
            $display("FAIL out_cycle: got cycle %0d, required cycle %0d", cyc, m_e.cyc);
          end
        end
      end
    end
  end

  function automatic logic [FB-1:0] filt_t1();
    int          f1[N_BANDS] = '{1000, 2000, 1500, 1200, 1100, 1300, 1400, 1250, 1350, 1450};
    logic [FB-1:0] r;
    for (int k = 0; k < N_BANDS; k++) r[k*FILT_W +: FILT_W] = FILT_W'(f1[k]);
    return r;
  endfunction

  function automatic logic [GB-1:0] gain_t1();
    logic [GB-1:0] r;
    for (int k = 0; k < N_BANDS; k++) r[k*GAIN_W +: GAIN_W] = GAIN_W'(k + 2);
    return r;
  endfunction

  task automatic send_sample(input logic [FB-1:0] f, input logic [GB-1:0] g);
    bit accepted = 0;
    bus_if.filt_bus     = f;
    bus_if.gain_bus     = g;
    bus_if.sample_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.sample_ready) begin
        accepted = 1;
        break;
      end
    end
    @(posedge clk); #1;
    bus_if.sample_valid = 1'b0;
    checks++;
    if (!accepted) begin
      failures++;
      $display("FAIL accept_timeout: got sample_ready=0 for 60 cycles, required 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending outputs, required 0", sb.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus_if.audio_out !== '0 || bus_if.out_valid !== 1'b0 || bus_if.wrap_flag !== 1'b0 ||
        bus_if.sample_drop !== 1'b0 || bus_if.sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s: got audio=%h ov=%b wrap=%b drop=%b ready=%b, required 0 0 0 0 1", tag,
               bus_if.audio_out, bus_if.out_valid, bus_if.wrap_flag, bus_if.sample_drop,
               bus_if.sample_ready);
    end
  endtask

  task automatic test_reset();
    bus_if.sample_valid = 1'b0;
    bus_if.filt_bus     = '0;
    bus_if.gain_bus     = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_sample(filt_t1(), gain_t1());
    wait_drain();
    // Explicit constant from the worked example: 87600 >> 16 = 1.
    checks++;
    if (bus_if.audio_out !== 24'd1) begin
      failures++;
      $display("FAIL basic_hold: got %h, required 000001", bus_if.audio_out);
    end
  endtask

  task automatic test_extremes();
    logic [FB-1:0] f;
    logic [GB-1:0] g;
    for (int k = 0; k < N_BANDS; k++) begin
      f[k*FILT_W +: FILT_W] = 16'h7FFF;
      g[k*GAIN_W +: GAIN_W] = 13'h1FFF;
    end
    send_sample(f, g);
    wait_drain();
    checks++;
    if (bus_if.audio_out !== 24'h009FF9) begin
      failures++;
      $display("FAIL max_pos: got %h, required 009ff9", bus_if.audio_out);
    end
    for (int k = 0; k < N_BANDS; k++) f[k*FILT_W +: FILT_W] = 16'h8000;
    send_sample(f, g);
    wait_drain();
    checks++;
    if (bus_if.audio_out !== 24'hFF6005) begin
      failures++;
      $display("FAIL max_neg: got %h, required ff6005", bus_if.audio_out);
    end
  endtask

  task automatic test_random();
    logic [FB-1:0] f;
    logic [GB-1:0] g;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < N_BANDS; k++) begin
        f[k*FILT_W +: FILT_W] = FILT_W'($urandom);
        g[k*GAIN_W +: GAIN_W] = GAIN_W'($urandom);
      end
      send_sample(f, g);
      wait_drain();
    end
  endtask

  task automatic test_back_to_back();
    int  ov_start;
    logic exp_ready;
    ov_start = ov_count;
    bus_if.filt_bus     = filt_t1();
    bus_if.gain_bus     = gain_t1();
    bus_if.sample_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      exp_ready = ((i % (N_BANDS + 1)) == 0);
      checks++;
      if (bus_if.sample_ready !== exp_ready || bus_if.sample_drop !== !exp_ready) begin
        failures++;
        $display("FAIL b2b_handshake[%0d]: got ready=%b drop=%b, required ready=%b drop=%b",
                 i, bus_if.sample_ready, bus_if.sample_drop, exp_ready, !exp_ready);
      end
    end
    @(posedge clk); #1;
    bus_if.sample_valid = 1'b0;
    checks++;
    if (ov_count - ov_start !== 2) begin
      failures++;
      $display("FAIL b2b_out_count: got %0d pulses, required 2", ov_count - ov_start);
    end
    wait_drain();
  endtask

  task automatic test_gain_change();
    send_sample(filt_t1(), gain_t1());
    @(posedge clk); #1;
    bus_if.gain_bus = '0;
    wait_drain();
    checks++;
    if (bus_if.audio_out !== 24'd1) begin
      failures++;
      $display("FAIL gain_isolation: got %h, required 000001", bus_if.audio_out);
    end
  endtask

  task automatic test_reset_mid();
    int ov_start;
    logic [FB-1:0] f;
    logic [GB-1:0] g;
    for (int k = 0; k < N_BANDS; k++) begin
      f[k*FILT_W +: FILT_W] = 16'h7FFF;
      g[k*GAIN_W +: GAIN_W] = 13'h1FFF;
    end
    // Leave a nonzero audio_out so the reset clear is observable.
    send_sample(f, g);
    wait_drain();
    send_sample(filt_t1(), gain_t1());
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_idle_outputs("mid_reset_outputs");
    ov_start = ov_count;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (ov_count !== ov_start) begin
      failures++;
      $display("FAIL mid_reset_no_output: got %0d pulses, required 0", ov_count - ov_start);
    end
    @(posedge clk); #1;
    send_sample(filt_t1(), gain_t1());
    wait_drain();
    checks++;
    if (bus_if.audio_out !== 24'd1) begin
      failures++;
      $display("FAIL after_reset_sample: got %h, required 000001", bus_if.audio_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_random();
    test_back_to_back();
    test_gain_change();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
